// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer for the execute stage.
// Runs mult/multu/div/divu one bit per cycle (shift-add multiply, restoring
// divide) over WIDTH cycles, then a single fix-up cycle that applies signs and
// loads the architectural HI/LO registers.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start_E      launch an operation (sampled only when idle)
//   op_E         00 mult, 01 multu, 10 div, 11 divu
//   srcA_E       multiplicand / dividend
//   srcB_E       multiplier / divisor
//   wr_hi_E      mthi write strobe (idle only)
//   wr_lo_E      mtlo write strobe (idle only)
//   wdata_E      mthi/mtlo data
//   need_hilo_D  decode holds an instruction that touches HI/LO
//   hi, lo       HI/LO registers
//   busy         operation in flight
//   done         one-cycle pulse when HI/LO have just been updated
//   stall_D      hold IF/ID and clear ID/EX (combinational)
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_E,
    input  logic [1:0]       op_E,
    input  logic [WIDTH-1:0] srcA_E,
    input  logic [WIDTH-1:0] srcB_E,
    input  logic             wr_hi_E,
    input  logic             wr_lo_E,
    input  logic [WIDTH-1:0] wdata_E,
    input  logic             need_hilo_D,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_D
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    // Mult: full product. Div: upper half is the partial remainder.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Mult: multiplicand. Div: dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0]   a_q, a_d;
    // Mult: multiplier (shifts right). Div: divisor.
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   orig_a_q, orig_a_d;
    logic               sign_q_q, sign_q_d;
    logic               sign_r_q, sign_r_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Multiply step
    logic [WIDTH:0]     mul_sum;
    // Divide step
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    // Fix-up
    logic [2*WIDTH-1:0] prod_fix;
    logic               last_iter;
    logic               is_signed;

    assign is_signed = ~op_E[0];
    assign last_iter = (count_q == CW'(WIDTH - 1));

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    // Extra top bit acts as the borrow/sign of the trial subtraction.
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign prod_fix  = sign_q_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        orig_a_d = orig_a_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_E) begin
                    // A same-cycle mthi/mtlo is dropped: start takes priority.
                    a_d      = (is_signed && srcA_E[WIDTH-1]) ? -srcA_E : srcA_E;
                    b_d      = (is_signed && srcB_E[WIDTH-1]) ? -srcB_E : srcB_E;
                    orig_a_d = srcA_E;
                    sign_q_d = is_signed & (srcA_E[WIDTH-1] ^ srcB_E[WIDTH-1]);
                    sign_r_d = is_signed & srcA_E[WIDTH-1];
                    is_div_d = op_E[1];
                    count_d  = '0;
                    acc_d    = '0;
                    state_d  = op_E[1] ? StDiv : StMul;
                end else begin
                    if (wr_hi_E) hi_d = wdata_E;
                    if (wr_lo_E) lo_d = wdata_E;
                end
            end
            StMul: begin
                acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StDiv: begin
                acc_d   = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                           acc_q[WIDTH-1:0]};
                a_d     = {a_q[WIDTH-2:0], div_ok};
                count_d = count_q + 1'b1;
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = orig_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = sign_q_q ? -a_q : a_q;
                end
                count_d = '0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            orig_a_q <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            orig_a_q <= orig_a_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign stall_D = need_hilo_D & (busy | start_E);

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the MIPS pipeline's execute stage. It accepts mult/multu/div/divu from EX and runs a 1-bit-per-cycle shift-add / restoring-divide datapath over WIDTH cycles. Results land in the architectural HI/LO registers. While the unit is busy it drives the decode-stage stall that holds the pipeline registers.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- start_E  in  1  launch operation; sampled only in IDLE
- op_E  in  2  00 mult, 01 multu, 10 div, 11 divu
- srcA_E  in  WIDTH  multiplicand / dividend
- srcB_E  in  WIDTH  multiplier / divisor
- wr_hi_E  in  1  mthi write strobe
- wr_lo_E  in  1  mtlo write strobe
- wdata_E  in  WIDTH  mthi/mtlo data
- need_hilo_D  in  1  decode holds mfhi/mflo/mthi/mtlo/mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO just updated
- stall_D  out  1  hold IF/ID, clear ID/EX

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, start_E=1:
  - Latch |srcA|, |srcB| for signed ops (op_E[0]=0), raw values for unsigned.
  - Record signQ = A[msb]^B[msb] and signR = A[msb], both forced 0 for unsigned.
  - Clear the count and accumulator. Go to MUL (op_E[1]=0) or DIV.
- MUL, WIDTH cycles: if multiplier LSB is 1, add multiplicand into the upper half of the 2·WIDTH accumulator. Then shift accumulator and multiplier right 1 with carry-in.
- DIV, WIDTH cycles, restoring: shift {rem, quo} left 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo LSB = 1. Otherwise restore rem.
- Counter counts 0..WIDTH-1; the last iteration moves to FIX.
- FIX, 1 cycle:
  - Mult: negate the 2·WIDTH product if signQ. hi = upper, lo = lower.
  - Div: lo = signQ ? −quo : quo; hi = signR ? −rem : rem.
  - HI and LO load at the end of FIX. Go to IDLE and pulse done.
- Divide by zero: the iteration still runs. Result is fixed: lo = all ones, hi = srcA (original, unsigned-abs not applied).
- mthi/mtlo:
  - In IDLE without start_E, wr_hi_E / wr_lo_E load wdata_E at the edge.
  - Same cycle as start_E: start wins and the write is dropped.
  - Ignored while busy.
- start_E while busy is ignored. Upstream stall_D guarantees this case does not occur.
- HI/LO hold their prior values throughout MUL/DIV/FIX.
- Arithmetic is modulo 2^WIDTH (2^(2·WIDTH) for the product). Signed −2^31 magnitude is 2^31, which is representable unsigned.

## Timing
- Reset (reset=0, async): state IDLE, hi=0, lo=0, busy=0, done=0, count=0. Reset mid-operation aborts, and HI/LO are zeroed.
- start_E sampled at edge T (cycle 0) → busy=1 in cycles 1..WIDTH+1.
  - MUL/DIV occupy cycles 1..WIDTH; FIX occupies cycle WIDTH+1.
  - In cycle WIDTH+2: busy=0, done=1, hi/lo valid.
- Total latency from start edge to result: WIDTH+2 cycles, i.e. 34 for WIDTH=32.
- done is high exactly one cycle. busy and done are never both 1.
- stall_D = need_hilo_D & (busy | start_E), combinational, no cycle of gap. Back-to-back ops therefore see the second start in the cycle where done=1.
- Registered outputs: hi, lo, busy, done. stall_D is the only combinational output.

## Test plan
- Signed mult 7 × −3 (0xFFFFFFFD), op 00 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at cycle 34, busy high cycles 1–33.
- divu 100 / 7, op 11 → lo=0x0000000E, hi=0x00000002. multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed div −7 / 2, op 10 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 1 → lo=0x80000000, hi=0.
- div 5 / 0 → lo=0xFFFFFFFF, hi=0x00000005. mthi 0x1234 in IDLE → hi=0x1234 next cycle. mthi with start_E in the same cycle → write dropped.
- need_hilo_D=1 during the op → stall_D=1 from the start cycle through cycle 33, 0 at cycle 34. need_hilo_D=0 → stall_D=0 throughout.
- Drive reset=0 at cycle 10 of a mult → immediately busy=0, hi=lo=0. A fresh start after release completes normally in 34 cycles.
